// File: rtl/a2d_pkg.sv
// Shared types and constants for the dual-channel SAR A2D controller.
package a2d_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } a2d_state_e;

    localparam int A2D_WIDTH    = 12;
    localparam int A2D_SMPL_CYC = 4;
    localparam int A2D_SETTLE   = 1;

    // Cycles from the accepting edge to the edge that raises cnv_cmplt
    function automatic int a2d_latency(input int width, input int smpl_cyc, input int settle);
        return 1 + smpl_cyc + width * (settle + 1);
    endfunction

endpackage

// File: rtl/sar_chnl.sv
// One SAR channel: WIDTH-bit trial register driven by the shared controller.
module sar_chnl
#(
    parameter int WIDTH = 12,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,   // load MSB-only trial code
    input  logic             i_dec,    // decision strobe for bit i_idx
    input  logic [IW-1:0]    i_idx,    // bit currently under test
    input  logic             i_gt,     // 1: trial code above analog value
    output logic [WIDTH-1:0] o_sar
);

    logic [WIDTH-1:0] r_sar;
    logic [WIDTH-1:0] w_nxt;

    // Next trial code: clear the tested bit if too high, then try the next bit down
    always_comb begin
        w_nxt = r_sar;
        if (i_load) begin
            w_nxt = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (i_dec) begin
            if (i_gt)
                w_nxt[i_idx] = 1'b0;
            if (i_idx != '0)
                w_nxt[i_idx - IW'(1)] = 1'b1;
        end
    end

    // Trial register
    always_ff @(posedge clk) begin
        if (rst)
            r_sar <= '0;
        else
            r_sar <= w_nxt;
    end

    assign o_sar = r_sar;

endmodule

// File: rtl/a2d_sar_ctrl.sv
// Dual-channel SAR A2D controller: sample strobe, lockstep binary search, result capture.
module a2d_sar_ctrl
    import a2d_pkg::*;
#(
    parameter int WIDTH    = A2D_WIDTH,
    parameter int SMPL_CYC = A2D_SMPL_CYC,
    parameter int SETTLE   = A2D_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_cnv,
    input  logic             gt_cos,
    input  logic             gt_sin,
    output logic             smpl,
    output logic [WIDTH-1:0] cosSAR,
    output logic [WIDTH-1:0] sinSAR,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out,
    output logic             busy,
    output logic             cnv_cmplt
);

    localparam int IW  = (WIDTH > 1)    ? $clog2(WIDTH)     : 1;
    localparam int SCW = (SMPL_CYC > 1) ? $clog2(SMPL_CYC)  : 1;
    localparam int STW = (SETTLE > 0)   ? $clog2(SETTLE+1)  : 1;

    a2d_state_e       r_state, w_nxt_state;
    logic [SCW-1:0]   r_smpl_cnt;
    logic [STW-1:0]   r_set_cnt;
    logic [IW-1:0]    r_idx;
    logic             r_smpl, r_busy, r_cnv_cmplt;
    logic [WIDTH-1:0] r_cos_out, r_sin_out;
    logic             w_load, w_dec, w_accept, w_smpl_last, w_bit_last;
    logic [WIDTH-1:0] w_cos_sar, w_sin_sar;

    assign w_smpl_last = (r_smpl_cnt == SCW'(SMPL_CYC - 1));
    assign w_bit_last  = (r_set_cnt == STW'(SETTLE));

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nxt_state;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (strt_cnv) begin
                    w_nxt_state = SAMPLE;
                    w_accept    = 1'b1;
                end
            end
            SAMPLE: begin
                if (w_smpl_last) begin
                    w_nxt_state = CONV;
                    w_load      = 1'b1;
                end
            end
            CONV: begin
                if (w_bit_last) begin
                    w_dec = 1'b1;
                    if (r_idx == '0)
                        w_nxt_state = DONE;
                end
            end
            DONE: begin
                // Final codes are committed on the edge leaving DONE, so a
                // back-to-back start still sees a completed result first.
                if (strt_cnv) begin
                    w_nxt_state = SAMPLE;
                    w_accept    = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Counters, strobes and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smpl_cnt  <= '0;
            r_set_cnt   <= '0;
            r_idx       <= '0;
            r_smpl      <= 1'b0;
            r_busy      <= 1'b0;
            r_cnv_cmplt <= 1'b0;
            r_cos_out   <= '0;
            r_sin_out   <= '0;
        end else begin
            r_cnv_cmplt <= (r_state == DONE);
            if (r_state == DONE) begin
                r_cos_out <= w_cos_sar;
                r_sin_out <= w_sin_sar;
            end
            if (w_accept) begin
                r_smpl     <= 1'b1;
                r_busy     <= 1'b1;
                r_smpl_cnt <= '0;
            end else if (r_state == SAMPLE) begin
                r_smpl_cnt <= r_smpl_cnt + SCW'(1);
                if (w_load) begin
                    r_smpl    <= 1'b0;
                    r_idx     <= IW'(WIDTH - 1);
                    r_set_cnt <= '0;
                end
            end else if (r_state == CONV) begin
                if (w_dec) begin
                    r_set_cnt <= '0;
                    r_idx     <= r_idx - IW'(1);
                    if (r_idx == '0)
                        r_busy <= 1'b0;
                end else begin
                    r_set_cnt <= r_set_cnt + STW'(1);
                end
            end
        end
    end

    sar_chnl #(.WIDTH(WIDTH), .IW(IW)) u_cos (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_idx  (r_idx),
        .i_gt   (gt_cos),
        .o_sar  (w_cos_sar)
    );

    sar_chnl #(.WIDTH(WIDTH), .IW(IW)) u_sin (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_idx  (r_idx),
        .i_gt   (gt_sin),
        .o_sar  (w_sin_sar)
    );

    assign smpl      = r_smpl;
    assign busy      = r_busy;
    assign cnv_cmplt = r_cnv_cmplt;
    assign cosSAR    = w_cos_sar;
    assign sinSAR    = w_sin_sar;
    assign cos_out   = r_cos_out;
    assign sin_out   = r_sin_out;

endmodule

// File: tb/tb_a2d_sar_ctrl.sv
// Scoreboard bench for a2d_sar_ctrl with an analog front-end model.
module tb_a2d_sar_ctrl;

    localparam int W      = 12;
    localparam int SMPL   = 4;
    localparam int HOLD   = 2;                  // SETTLE + 1
    localparam int LAT    = 1 + SMPL + W*HOLD;  // 29

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] s;
        int           cyc;
        bit           chk_busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         strt_cnv = 1'b0;
    logic         gt_cos, gt_sin;
    logic         smpl, busy, cnv_cmplt;
    logic [W-1:0] cosSAR, sinSAR, cos_out, sin_out;

    logic [W-1:0] a_cos = '0, a_sin = '0;     // analog inputs
    logic [W-1:0] cap_cos = '0, cap_sin = '0; // sampled values
    logic         smpl_prev = 1'b0;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    a2d_sar_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .gt_cos    (gt_cos),
        .gt_sin    (gt_sin),
        .smpl      (smpl),
        .cosSAR    (cosSAR),
        .sinSAR    (sinSAR),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Analog side: capture on the falling edge of smpl, compare DAC code to held value
    always @(negedge clk) begin
        if (smpl_prev && !smpl) begin
            cap_cos = a_cos;
            cap_sin = a_sin;
        end
        smpl_prev = smpl;
    end
    assign gt_cos = (cosSAR > cap_cos);
    assign gt_sin = (sinSAR > cap_sin);

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected trial code on the k-th cycle after the MSB load: bits above the
    // one under test follow the analog value, the tested bit is 1, the rest 0.
    function automatic int trial(input int v, input int k);
        int i;
        i = W - 1 - k / HOLD;
        return ((v >> (i + 1)) << (i + 1)) | (1 << i);
    endfunction

    // Monitor: every cnv_cmplt pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (cnv_cmplt) begin
            if (sb.size() == 0) begin
                chk("spurious_cmplt", int'(cnv_cmplt), 0);
            end else begin
                e = sb.pop_front();
                chk("cos_out", int'(cos_out), int'(e.c));
                chk("sin_out", int'(sin_out), int'(e.s));
                chk("latency_cycle", cyc, e.cyc);
                if (e.chk_busy)
                    chk("busy_in_done", int'(busy), 0);
            end
        end
    end

    // One conversion with optional trial-code tracing and start re-assertion
    task automatic conv(input logic [W-1:0] c, input logic [W-1:0] s,
                        input bit trace, input bit poke);
        exp_t e;
        int   a;
        a_cos = c;
        a_sin = s;
        strt_cnv = 1'b1;
        a = cyc + 1;
        e.c = c; e.s = s; e.cyc = a + LAT; e.chk_busy = 1'b1;
        sb.push_back(e);
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            strt_cnv = poke && (k == 1 || k == 12);
            chk($sformatf("smpl_k%0d", k), int'(smpl), (k < SMPL) ? 1 : 0);
            if (k < LAT - 1)
                chk($sformatf("busy_k%0d", k), int'(busy), (k < SMPL + W*HOLD) ? 1 : 0);
            if (trace && k >= SMPL && k < SMPL + W*HOLD)
                chk($sformatf("cosSAR_trial_k%0d", k), int'(cosSAR), trial(int'(c), k - SMPL));
            if (trace && k >= SMPL && k < SMPL + W*HOLD)
                chk($sformatf("sinSAR_trial_k%0d", k), int'(sinSAR), trial(int'(s), k - SMPL));
        end
        strt_cnv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_smpl", int'(smpl), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmplt", int'(cnv_cmplt), 0);
        chk("rst_cosSAR", int'(cosSAR), 0);
        chk("rst_cos_out", int'(cos_out), 0);
        chk("rst_sin_out", int'(sin_out), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Basic conversion and trial sequences
        conv(12'hA5C, 12'h3F1, 1'b0, 1'b0);
        conv(12'h800, 12'h7FF, 1'b1, 1'b0);
        conv(W'($urandom), W'($urandom), 1'b1, 1'b0);

        // Extremes
        conv(12'h000, 12'hFFF, 1'b0, 1'b0);
        conv(12'hFFF, 12'h000, 1'b0, 1'b0);

        // Start re-asserted during SAMPLE and CONV is ignored
        conv(12'h123, 12'hC3A, 1'b0, 1'b1);

        // Reset during bit 6 aborts the conversion
        a_cos = 12'hBEE;
        a_sin = 12'h421;
        strt_cnv = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        strt_cnv = 1'b0;
        while (cyc < a + SMPL + 5*HOLD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_smpl", int'(smpl), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cosSAR", int'(cosSAR), 0);
        chk("abort_sinSAR", int'(sinSAR), 0);
        chk("abort_cos_out", int'(cos_out), 0);
        chk("abort_sin_out", int'(sin_out), 0);
        repeat (LAT + 5) @(negedge clk);
        chk("abort_no_result", int'(cos_out), 0);
        conv(12'h5A5, W'($urandom), 1'b0, 1'b0);

        // Back-to-back with strt_cnv held high
        a = cyc + 1;
        a_cos = W'($urandom);
        a_sin = W'($urandom);
        strt_cnv = 1'b1;
        for (int n = 0; n < 4; n++) begin
            e.c = a_cos; e.s = a_sin; e.cyc = a + n*LAT + LAT; e.chk_busy = 1'b0;
            sb.push_back(e);
            repeat (10) @(negedge clk);
            if (n < 3) begin
                a_cos = W'($urandom);
                a_sin = W'($urandom);
            end else begin
                strt_cnv = 1'b0;
            end
            repeat (LAT - 10) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Random single conversions
        for (int n = 0; n < 8; n++)
            conv(W'($urandom), W'($urandom), 1'b0, 1'b0);

        repeat (LAT + 5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
